// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SYNC/LEN/PAYLOAD/XOR-checksum frame parser feeding a payload write port
module uart_frame_parser #(
  parameter int         MAX_LEN = 16,
  parameter int         ADDR_W  = 4,
  parameter int         TIMEOUT = 1023,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHECK} state_t;

  state_t            state, state_nx;
  logic [7:0]        len, len_nx;
  logic [7:0]        chk, chk_nx;
  logic [7:0]        idx, idx_nx;
  logic [GAP_W-1:0]  gap, gap_nx;
  logic              wr_en_nx, frame_ok_nx, frame_err_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [7:0]        wr_data_nx;
  logic [1:0]        err_code_nx;
  logic              abort;
  logic [1:0]        abort_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      chk       <= '0;
      idx       <= '0;
      gap       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_nx;
      len       <= len_nx;
      chk       <= chk_nx;
      idx       <= idx_nx;
      gap       <= gap_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      frame_ok  <= frame_ok_nx;
      frame_err <= frame_err_nx;
      err_code  <= err_code_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    len_nx       = len;
    chk_nx       = chk;
    idx_nx       = idx;
    gap_nx       = rx_done ? '0 : gap + 1'b1;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = wr_addr;
    wr_data_nx   = wr_data;
    frame_ok_nx  = 1'b0;
    frame_err_nx = 1'b0;
    err_code_nx  = err_code;
    abort        = 1'b0;
    abort_code   = 2'b00;

    if (state == IDLE) begin
      gap_nx = '0;
      if (rx_done && rx_data == SYNC)
        state_nx = LEN;
    end else if (rx_err) begin
      // a link error outranks a byte arriving in the same cycle
      abort      = 1'b1;
      abort_code = 2'b11;
    end else if (rx_done) begin
      case (state)
        LEN: begin
          len_nx = rx_data;
          chk_nx = rx_data;
          idx_nx = '0;
          if (rx_data == 8'd0 || {1'b0, rx_data} > 9'(MAX_LEN)) begin
            abort      = 1'b1;
            abort_code = 2'b01;
          end else begin
            state_nx = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = ADDR_W'(idx);
          wr_data_nx = rx_data;
          chk_nx     = chk ^ rx_data;
          idx_nx     = idx + 8'd1;
          if (({1'b0, idx} + 9'd1) == {1'b0, len})
            state_nx = CHECK;
        end
        CHECK: begin
          if (rx_data == chk) begin
            frame_ok_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = 2'b10;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (gap == GAP_W'(TIMEOUT)) begin
      abort      = 1'b1;
      abort_code = 2'b11;
    end

    if (abort) begin
      frame_err_nx = 1'b1;
      err_code_nx  = abort_code;
      state_nx     = IDLE;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed and randomized frame checks against a frame-level model
module tb_uart_frame_parser;

  localparam int         MAX_LEN = 16;
  localparam int         ADDR_W  = 4;
  localparam int         TIMEOUT = 1023;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              rx_err = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;
  logic [1:0] exp_code = 2'b00;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .SYNC   (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_err   (rx_err),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_frame_ok"}, frame_ok, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // one received byte, then the registered response one cycle later
  task automatic send(input logic [7:0] b, input logic e_wr, input int e_addr,
                      input logic [7:0] e_data, input logic e_ok, input logic e_err,
                      input logic [1:0] e_code, input logic e_busy, input logic err_in);
    rx_data = b;
    rx_done = 1'b1;
    rx_err  = err_in;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    if (e_err) exp_code = e_code;
    check("wr_en", wr_en, e_wr);
    if (e_wr) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
    end
    check("frame_ok", frame_ok, e_ok);
    check("frame_err", frame_err, e_err);
    check("err_code", err_code, exp_code);
    check("busy", busy, e_busy);
  endtask

  task automatic plain(input logic [7:0] b, input logic e_busy);
    send(b, 0, 0, 8'h00, 0, 0, 2'b00, e_busy, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check("quiet_wr_en", wr_en, 0);
      check("quiet_frame_ok", frame_ok, 0);
      check("quiet_frame_err", frame_err, 0);
    end
  endtask

  // Frame-level model: outcome follows from the frame's length byte and checksum
  task automatic rand_frame(input logic [7:0] lenv, input bit corrupt);
    logic [7:0] x;
    logic [7:0] d;
    int ng;
    ng = $urandom_range(0, 2);
    for (int g = 0; g < ng; g++) begin
      d = 8'($urandom);
      if (d == SYNC) d = 8'h00;
      plain(d, 0);
      idle($urandom_range(0, 2));
    end
    plain(SYNC, 1);
    if (lenv == 8'd0 || int'(lenv) > MAX_LEN) begin
      send(lenv, 0, 0, 8'h00, 0, 1, 2'b01, 0, 0);
      return;
    end
    plain(lenv, 1);
    x = lenv;
    for (int i = 0; i < int'(lenv); i++) begin
      d = 8'($urandom);
      x = x ^ d;
      idle($urandom_range(0, 2));
      send(d, 1, i, d, 0, 0, 2'b00, 1, 0);
    end
    idle($urandom_range(0, 2));
    if (corrupt) begin
      d = x ^ 8'($urandom_range(1, 255));
      send(d, 0, 0, 8'h00, 0, 1, 2'b10, 0, 0);
    end else begin
      send(x, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0);
    end
  endtask

  initial begin
    int seen;
    int r;
    logic [7:0] lv;

    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // A5,03,11,22,33,03: good frame of three bytes
    plain(SYNC, 1);
    plain(8'h03, 1);
    send(8'h11, 1, 0, 8'h11, 0, 0, 2'b00, 1, 0);
    send(8'h22, 1, 1, 8'h22, 0, 0, 2'b00, 1, 0);
    send(8'h33, 1, 2, 8'h33, 0, 0, 2'b00, 1, 0);
    send(8'h03, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0);
    idle(2);

    // A5,02,10,20,00: writes happen, then checksum abort
    plain(SYNC, 1);
    plain(8'h02, 1);
    send(8'h10, 1, 0, 8'h10, 0, 0, 2'b00, 1, 0);
    send(8'h20, 1, 1, 8'h20, 0, 0, 2'b00, 1, 0);
    send(8'h00, 0, 0, 8'h00, 0, 1, 2'b10, 0, 0);
    idle(1);

    // zero and over-length lengths
    plain(SYNC, 1);
    send(8'h00, 0, 0, 8'h00, 0, 1, 2'b01, 0, 0);
    idle(1);
    plain(SYNC, 1);
    send(8'h11, 0, 0, 8'h00, 0, 1, 2'b01, 0, 0);
    idle(1);

    // maximum length frame writes 0..MAX_LEN-1
    rand_frame(8'(MAX_LEN), 0);

    // inter-byte timeout
    plain(SYNC, 1);
    plain(8'h04, 1);
    send(8'h01, 1, 0, 8'h01, 0, 0, 2'b00, 1, 0);
    seen = -1;
    for (int j = 1; j <= TIMEOUT + 4 && seen < 0; j++) begin
      tick();
      if (frame_err) seen = j;
    end
    check("timeout_window", (seen >= TIMEOUT && seen <= TIMEOUT + 1), 1);
    exp_code = 2'b11;
    check("timeout_code", err_code, exp_code);
    check("timeout_busy", busy, 0);
    plain(SYNC, 1);
    plain(8'h01, 1);
    send(8'h7E, 1, 0, 8'h7E, 0, 0, 2'b00, 1, 0);
    send(8'h7F, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0);

    // a byte arriving exactly as the gap counter hits its limit is accepted
    plain(SYNC, 1);
    plain(8'h02, 1);
    send(8'hAA, 1, 0, 8'hAA, 0, 0, 2'b00, 1, 0);
    idle(TIMEOUT);
    send(8'hBB, 1, 1, 8'hBB, 0, 0, 2'b00, 1, 0);
    send(8'h13, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0);

    // leading junk ignored, SYNC value inside a frame is data
    plain(8'h5A, 0);
    plain(8'hFF, 0);
    plain(SYNC, 1);
    plain(8'h01, 1);
    send(SYNC, 1, 0, SYNC, 0, 0, 2'b00, 1, 0);
    send(8'hA4, 0, 0, 8'h00, 1, 0, 2'b00, 0, 0);

    // rx_err in IDLE is ignored
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    check("idle_err_frame_err", frame_err, 0);
    check("idle_err_busy", busy, 0);
    check("idle_err_code", err_code, exp_code);

    // rx_err coincident with a payload byte: abort, byte dropped
    plain(SYNC, 1);
    plain(8'h03, 1);
    send(8'h11, 1, 0, 8'h11, 0, 0, 2'b00, 1, 0);
    send(8'h22, 0, 0, 8'h00, 0, 1, 2'b11, 0, 1);
    idle(1);

    // reset mid-payload clears everything at once, no frame_err
    plain(SYNC, 1);
    plain(8'h03, 1);
    send(8'h11, 1, 0, 8'h11, 0, 0, 2'b00, 1, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_code = 2'b00;
    tick();
    check("reset_hold_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick();
    plain(8'h22, 0);
    rand_frame(8'h03, 0);

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) lv = 8'h00;
      else if (r == 1) lv = 8'($urandom_range(MAX_LEN + 1, 255));
      else lv = 8'($urandom_range(1, MAX_LEN));
      rand_frame(lv, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame (1..256).
REQ-002 SHALL have parameter ADDR_W, default 4: width of wr_addr; 2**ADDR_W >= MAX_LEN.
REQ-003 SHALL have parameter TIMEOUT, default 1023: inter-byte gap limit in clk cycles while a frame is open.
REQ-004 SHALL have parameter SYNC, default 8'hA5: frame start byte.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge; one clock, shared with the upstream 8-bit receiver.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx_data  input  8  received byte from upstream receiver.
REQ-008 SHALL have port rx_done  input  1  one-cycle strobe; rx_data valid in that cycle.
REQ-009 SHALL have port rx_err  input  1  upstream framing error; level or pulse.
REQ-010 SHALL have port wr_en  output  1  one-cycle payload write strobe to matrix buffer.
REQ-011 SHALL have port wr_addr  output  ADDR_W  payload byte index, 0-based.
REQ-012 SHALL have port wr_data  output  8  payload byte.
REQ-013 SHALL have port frame_ok  output  1  one-cycle pulse: frame complete, checksum good.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse: frame aborted.
REQ-015 SHALL have port err_code  output  2  cause of last abort: 01 length, 10 checksum, 11 timeout/link; held until next abort or reset.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LEN, PAYLOAD, CHECK; registered outputs only.
REQ-018 IDLE: rx_done with rx_data==SYNC -> LEN; any other byte ignored, no error.
REQ-019 LEN: rx_done latches len=rx_data, chk=rx_data, idx=0; len 0 or len>MAX_LEN -> abort code 01, else -> PAYLOAD.
REQ-020 PAYLOAD: each rx_done asserts wr_en next cycle with wr_addr=idx, wr_data=rx_data; chk^=rx_data; idx+=1; after byte len-1 -> CHECK.
REQ-021 CHECK: rx_done compares rx_data to chk; equal -> frame_ok pulse, else abort code 10; both -> IDLE.
REQ-022 Output latency: wr_en/frame_ok/frame_err SHALL assert exactly 1 cycle after the causing rx_done.
REQ-023 Payload writes SHALL NOT be suppressed on later checksum failure; consumer qualifies data with frame_ok.
REQ-024 Gap counter SHALL clear on every rx_done and while in IDLE; count up otherwise; reaching TIMEOUT in a non-IDLE state -> abort code 11.
REQ-025 rx_err high in a non-IDLE state -> abort code 11; rx_err in IDLE ignored.
REQ-026 Abort SHALL pulse frame_err 1 cycle, set err_code, return to IDLE; next SYNC starts a fresh frame.
REQ-027 Simultaneous rx_err and rx_done: rx_err wins, byte discarded, no wr_en.
REQ-028 Simultaneous rx_done and gap counter at TIMEOUT: byte accepted, no timeout.
REQ-029 SYNC value inside LEN/PAYLOAD/CHECK SHALL be treated as data, not resync.
REQ-030 idx SHALL never wrap; len==MAX_LEN writes addresses 0..MAX_LEN-1 only.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_ok=0, frame_err=0, err_code=00, busy=0, counters/chk cleared.
REQ-032 Reset mid-frame SHALL discard the frame with no frame_err pulse; first byte after release is parsed from IDLE.

Verification
REQ-033 Bytes A5,03,11,22,33,03 -> wr_en x3 (addr0=11,addr1=22,addr2=33), frame_ok 1 cycle after last byte, err_code 00.
REQ-034 Bytes A5,02,10,20,00 -> two writes, frame_err, err_code 10, busy 0.
REQ-035 Bytes A5,00 and separately A5,11 (MAX_LEN=16) -> frame_err code 01, no wr_en.
REQ-036 Bytes A5,04,01 then 1023 idle cycles -> frame_err code 11; following A5,01,7E,7F -> frame_ok, write addr0=7E.
REQ-037 Bytes 5A,FF,A5,01,A5,A4 -> leading bytes ignored, A5 payload written at addr0, frame_ok.
REQ-038 rx_err pulse during PAYLOAD coincident with rx_done, and rst_n low mid-PAYLOAD -> code 11/no write; reset: all outputs zero, no frame_err.
